audio_stream_arbiter: RTL and testbench
=======================================

# audio_stream_arbiter

Round-robin arbiter that shares the single parallel-in/serial-out audio output path between two ready/valid stereo-sample sources, e.g. FIFO passthrough and a tone generator. It sits between the sources and the PISO input interface. It grants one source at a time for a burst of up to `burst_p` samples, so switching only happens on whole-sample boundaries. Output is registered with full backpressure and no sample loss.

## Interface
Parameters:
- `width_p`, default 48: sample width, {right[23:0], left[23:0]}.
- `burst_p`, default 4: maximum samples accepted per grant; legal range ≥1.

Ports:
- `clk_i` input, 1: the single clock.
- `reset_i` input, 1: reset, asynchronous, active-high.
- `data0_i` input, `width_p`: source 0 sample.
- `valid0_i` input, 1: source 0 has a sample.
- `ready0_o` output, 1: arbiter accepts from source 0.
- `data1_i` input, `width_p`: source 1 sample.
- `valid1_i` input, 1: source 1 has a sample.
- `ready1_o` output, 1: arbiter accepts from source 1.
- `data_o` output, `width_p`: registered output sample.
- `valid_o` output, 1: `data_o` holds a sample.
- `ready_i` input, 1: downstream (PISO) accepts.
- `grant_o` output, 2: one-hot current owner; 00 when idle.

## Operation
- State machine states: IDLE, GRANT0, GRANT1. Supporting registers: `last_r` (last owner), `cnt_r` (`$clog2(burst_p+1)` bits), and an output register (`data_o`, `valid_o`).
- **Reset** (async, takes effect immediately, no clock edge needed):
  - state = IDLE, `last_r` = 1, `cnt_r` = 0.
  - `valid_o` = 0, `data_o` = 0, `grant_o` = 00, `ready0_o` = `ready1_o` = 0.
  - An in-flight output sample is discarded.
- **Space:** `space` = `~valid_o | ready_i`.
- **Ready:** `readyk_o` = (state == GRANTk) & `space`. It is combinational from state, `valid_o` and `ready_i`, and never depends on `validk_i`.
- **Accept:** a sample is accepted on a rising edge where `validk_i & readyk_o`. At that edge `data_o` <= `datak_i`, `valid_o` <= 1, `cnt_r` += 1.
- **Drain:** if `valid_o & ready_i` and nothing is accepted, `valid_o` <= 0 and `data_o` holds its value.
- **Arbitration function** `pick(last)`:
  - If both sources are valid, grant the one that is not `last`.
  - If only one is valid, grant that one.
  - If none is valid, go to IDLE.
- **IDLE:** each edge, state <= `pick(last_r)`, `cnt_r` <= 0.
- **GRANTk:** the grant is released on an edge when either condition holds:
  - (a) an accept occurs that makes `cnt_r` reach `burst_p`;
  - (b) `validk_i` = 0.
- **On release:** `last_r` <= k, `cnt_r` <= 0, state <= `pick(k)`.
  - Re-granting the same source straight from GRANTk is allowed, with a fresh count.
- **Holding:** while `validk_i` = 1 and the burst is not exhausted, GRANTk is held even when `space` = 0 (backpressure stalls, it does not release).
- **Protocol:**
  - Sources must hold data stable while valid and not ready.
  - `data_o` is stable while `valid_o & ~ready_i`.
- **Ordering:** per-source order is preserved and no sample is duplicated or dropped.

## Timing
- **Arbitration latency:** with state IDLE and `validk_i` rising before edge N, GRANTk takes effect from edge N, `readyk_o` = 1 in cycle N, and the first accept is at edge N+1.
- **Data latency:** an accepted sample appears on `data_o` with `valid_o` = 1 in the cycle after acceptance (1 cycle).
- **Throughput:** with `ready_i` = 1 continuously, one sample per cycle.
- **Switch bubbles:**
  - Switching between sources on burst exhaustion costs 0 bubbles.
  - A release caused by (b) costs the one cycle in which `validk_i` was low.
- **Simultaneous events:**
  - Accept and drain in the same edge: the output register is replaced and `valid_o` stays 1.
  - Burst end while both sources are valid: ownership alternates.
- **Tie after reset:** first tie goes to source 0 (`last_r` = 1).
- **`burst_p` = 1:** ownership alternates every sample under continuous contention.

## Test plan
1. **Reset:** assert `reset_i` mid-stream with no clock edge -> `valid_o`, `grant_o`, `ready0_o`, `ready1_o` all 0 immediately. Deassert with no valids -> state stays IDLE.
2. **Single source:** source 0 streams A0..A5, `ready_i` = 1, `burst_p` = 4 -> `grant_o` = 01 throughout. Out A0..A5 on consecutive cycles. First `valid_o` arrives 2 cycles after `valid0_i` rises.
3. **Continuous contention:** both sources valid (A*, B*), `ready_i` = 1 -> output A0..A3, B0..B3, A4..A7, with no gap cycles.
4. **Backpressure:** during a source 0 burst, `ready_i` = 0 for 3 cycles with `valid_o` = 1 -> `data_o` held constant, `ready0_o` = 0, `cnt_r` frozen. The sequence resumes without loss or duplicate.
5. **Early release:** source 1 granted, sends B0, B1, then drops valid while source 0 is valid -> `grant_o` = 01 after one idle-input cycle. A0 follows B1 with exactly one bubble.
6. **`burst_p` = 1 with a late requester:** source 0 continuous, source 1 joins at cycle 10 -> after source 1 joins, output strictly alternates A, B, A, B.

Source files
------------

// File: rtl/audio_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : audio_stream_arbiter
// Purpose  : Burst round-robin arbiter merging two stereo-sample streams into a
//            registered ready/valid output feeding the PISO serializer.
// Revision : 1.0
// ============================================================================
module audio_stream_arbiter #(
   parameter int width_p = 48,
   parameter int burst_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] data0_i,
   input  logic               valid0_i,
   output logic               ready0_o,
   input  logic [width_p-1:0] data1_i,
   input  logic               valid1_i,
   output logic               ready1_o,
   output logic [width_p-1:0] data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [1:0]         grant_o
);

   localparam int CW = $clog2(burst_p + 1);
   localparam logic [CW-1:0] c_burst = CW'(burst_p);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last;
   logic               w_last_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic [CW-1:0]      w_cnt_inc;
   logic [width_p-1:0] r_data;
   logic               r_valid;
   logic               w_space;
   logic               w_acc0;
   logic               w_acc1;

   // On a tie the source that did not own the path last time wins.
   function automatic state_t pick(input logic last, input logic v0, input logic v1);
      if (v0 && v1)
         return last ? GRANT0 : GRANT1;
      else if (v0)
         return GRANT0;
      else if (v1)
         return GRANT1;
      else
         return IDLE;
   endfunction

   assign w_space   = ~r_valid | ready_i;
   assign ready0_o  = (r_state == GRANT0) & w_space;
   assign ready1_o  = (r_state == GRANT1) & w_space;
   assign w_acc0    = valid0_i & ready0_o;
   assign w_acc1    = valid1_i & ready1_o;
   assign w_cnt_inc = r_cnt + 1'b1;

   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign grant_o = {r_state == GRANT1, r_state == GRANT0};

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            w_state_nxt = pick(r_last, valid0_i, valid1_i);
            w_cnt_nxt   = '0;
         end
         GRANT0: begin
            if ((w_acc0 && (w_cnt_inc == c_burst)) || !valid0_i) begin
               w_last_nxt  = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = pick(1'b0, valid0_i, valid1_i);
            end else if (w_acc0) begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         GRANT1: begin
            if ((w_acc1 && (w_cnt_inc == c_burst)) || !valid1_i) begin
               w_last_nxt  = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = pick(1'b1, valid0_i, valid1_i);
            end else if (w_acc1) begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // An accept overrides a simultaneous drain so the register is simply replaced.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_acc0 || w_acc1) begin
         r_data  <= w_acc0 ? data0_i : data1_i;
         r_valid <= 1'b1;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_stream_arbiter
// Purpose  : Randomized scoreboard bench for two arbiter instances (burst 4, 1).
// Revision : 1.0
// ============================================================================
module tb_audio_stream_arbiter;

   typedef logic [47:0] word_t;

   logic       clk;
   logic       rst;
   word_t      din    [2][2];
   logic       vld    [2][2];
   logic       rdy_out[2][2];
   word_t      dout   [2];
   logic       vout   [2];
   logic       rdy    [2];
   logic [1:0] gnt    [2];

   int n_checks = 0;
   int n_err    = 0;
   int seq      = 0;

   int owner[2];
   int last [2];
   int cnt  [2];
   bit full [2];
   bit acc  [2][2];

   word_t exp_q0[$];
   word_t exp_q1[$];

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_dut
         audio_stream_arbiter #(
            .width_p(48),
            .burst_p((g == 0) ? 4 : 1)
         ) u_dut (
            .clk_i   (clk),
            .reset_i (rst),
            .data0_i (din[g][0]),
            .valid0_i(vld[g][0]),
            .ready0_o(rdy_out[g][0]),
            .data1_i (din[g][1]),
            .valid1_i(vld[g][1]),
            .ready1_o(rdy_out[g][1]),
            .data_o  (dout[g]),
            .valid_o (vout[g]),
            .ready_i (rdy[g]),
            .grant_o (gnt[g])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int burst_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic int m_pick(input int prev, input bit v0, input bit v1);
      if (v0 && v1) return 1 - prev;
      if (v0)       return 0;
      if (v1)       return 1;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic push(input int d, input word_t w);
      if (d == 0) exp_q0.push_back(w);
      else        exp_q1.push_back(w);
   endtask

   // Monitor: each sample leaving a DUT must be the oldest expected one.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (vout[d] && rdy[d]) begin
               if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                  chk($sformatf("underflow[%0d]", d), 64'(dout[d]), 64'hFFFF_FFFF_FFFF_FFFF);
               end else if (d == 0) begin
                  chk("data_o[0]", 64'(dout[0]), 64'(exp_q0.pop_front()));
               end else begin
                  chk("data_o[1]", 64'(dout[1]), 64'(exp_q1.pop_front()));
               end
            end
         end
      end
   end

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1;
         last[d]  = 1;
         cnt[d]   = 0;
         full[d]  = 1'b0;
         for (int k = 0; k < 2; k++) begin
            acc[d][k] = 1'b0;
            vld[d][k] = 1'b0;
            din[d][k] = '0;
         end
         rdy[d] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   task automatic check_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_valid[%0d]", d),  64'(vout[d]),       64'd0);
         chk($sformatf("rst_grant[%0d]", d),  64'(gnt[d]),        64'd0);
         chk($sformatf("rst_ready0[%0d]", d), 64'(rdy_out[d][0]), 64'd0);
         chk($sformatf("rst_ready1[%0d]", d), 64'(rdy_out[d][1]), 64'd0);
         chk($sformatf("rst_data[%0d]", d),   64'(dout[d]),       64'd0);
      end
   endtask

   // Sources offer a new sample only after the previous one was taken.
   task automatic drive(input int p0, input int p1, input int prdy);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 2; k++) begin
            if (acc[d][k] || !vld[d][k]) begin
               vld[d][k] = ($urandom_range(99) < ((k == 0) ? p0 : p1));
               if (vld[d][k]) begin
                  seq++;
                  din[d][k] = {16'($urandom), 1'(k), 31'(seq)};
               end
            end
         end
         rdy[d] = ($urandom_range(99) < prdy);
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit space;
         bit r0;
         bit r1;
         int k;
         space = !full[d] || rdy[d];
         r0 = (owner[d] == 0) && space;
         r1 = (owner[d] == 1) && space;
         chk($sformatf("ready0[%0d]", d), 64'(rdy_out[d][0]), 64'(r0));
         chk($sformatf("ready1[%0d]", d), 64'(rdy_out[d][1]), 64'(r1));
         chk($sformatf("grant[%0d]", d),  64'(gnt[d]), {62'd0, owner[d] == 1, owner[d] == 0});
         chk($sformatf("valid_o[%0d]", d), 64'(vout[d]), 64'(full[d]));
         acc[d][0] = vld[d][0] && r0;
         acc[d][1] = vld[d][1] && r1;
         if (acc[d][0]) push(d, din[d][0]);
         if (acc[d][1]) push(d, din[d][1]);
         if (acc[d][0] || acc[d][1]) full[d] = 1'b1;
         else if (rdy[d])            full[d] = 1'b0;
         if (owner[d] < 0) begin
            owner[d] = m_pick(last[d], vld[d][0], vld[d][1]);
            cnt[d]   = 0;
         end else begin
            k = owner[d];
            if (acc[d][k]) cnt[d]++;
            if ((acc[d][k] && cnt[d] == burst_of(d)) || !vld[d][k]) begin
               last[d]  = k;
               cnt[d]   = 0;
               owner[d] = m_pick(k, vld[d][0], vld[d][1]);
            end
         end
      end
   endtask

   task automatic run(input int n, input int p0, input int p1, input int prdy);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive(p0, p1, prdy);
         @(negedge clk);
         model_step();
      end
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      #2;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      run(12, 0, 0, 100);
      run(20, 100, 0, 100);
      run(40, 100, 100, 100);
      run(300, 70, 70, 60);
      run(10, 100, 0, 100);
      run(40, 100, 100, 100);
      run(300, 50, 80, 30);

      // Asynchronous reset between edges, with traffic likely still in flight.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs();
      model_reset();
      run(3, 0, 0, 100);
      @(posedge clk);
      #2 rst = 1'b0;
      run(6, 0, 0, 100);

      run(400, 80, 80, 50);
      run(30, 0, 0, 100);
      chk("drain_q0", 64'(exp_q0.size()), 64'd0);
      chk("drain_q1", 64'(exp_q1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
